// File: rtl/mb_rtu_frame_tx.sv
// mb_rtu_frame_tx: Modbus RTU frame transmitter.
// Builds request or register-read response frames, appends CRC-16/Modbus
// (reflected 0xA001, init 0xFFFF) low byte first, and streams the frame over a
// valid/ready byte interface towards the UART byte transmitter.
// Optional feature macro: MB_T35_GAP_EN inserts a t3.5 silent gap before tx_done.
module mb_rtu_frame_tx #(
  parameter int MAX_REGS = 125,
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic        mode,
  input  logic [7:0]  slave_id,
  input  logic [7:0]  fun,
  input  logic [15:0] start_addr,
  input  logic [15:0] reg_num,
  output logic        payload_req,
  input  logic [7:0]  payload_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic        busy,
  output logic        tx_done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    BODY   = 3'd2,
    DATA   = 3'd3,
    CRC_LO = 3'd4,
    CRC_HI = 3'd5,
    GAP    = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [1:0]  idx;
  logic [7:0]  req_cnt;
  logic        pending;
  logic        mode_r;
  logic [7:0]  id_r, fun_r, count_r;
  logic [15:0] addr_r, num_r;
  logic [15:0] crc;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        done_r, err_r;
  logic        load_en, fold_en, req;
  logic [7:0]  load_byte;
  logic        fire, can_load, bad_num, accept;

  // Fold one byte into the running CRC, LSB first, in a single cycle.
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ 16'hA001;
      else      r = r >> 1;
    end
    return r;
  endfunction

  assign fire     = out_valid & byte_ready;
  assign can_load = ~out_valid | fire;
  assign bad_num  = mode & ((reg_num == 16'd0) | (reg_num > 16'(MAX_REGS)));
  assign accept   = (state == IDLE) & tx_start & ~bad_num;

`ifdef MB_T35_GAP_EN
  localparam int unsigned GAP_CYC = (CLK_FREQ / BAUD) * 39;
  logic [31:0] gap_cnt;

  // Gap timer: counts silent cycles while in GAP, cleared elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              gap_cnt <= '0;
    else if (state == GAP)   gap_cnt <= gap_cnt + 32'd1;
    else                     gap_cnt <= '0;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: each byte slot advances once its byte is loaded.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept) state_next = HDR;
      HDR:    if (load_en && idx == 2'd1) state_next = BODY;
      BODY:   if (load_en && (mode_r || idx == 2'd3)) state_next = mode_r ? DATA : CRC_LO;
      DATA:   if (load_en && req_cnt == count_r) state_next = CRC_LO;
      CRC_LO: if (load_en) state_next = CRC_HI;
      CRC_HI: begin
        if (idx[0] && fire) begin
`ifdef MB_T35_GAP_EN
          state_next = GAP;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef MB_T35_GAP_EN
      GAP:    if (gap_cnt == 32'(GAP_CYC - 1)) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output logic: choose the byte to load, whether it enters the CRC, and payload requests.
  always_comb begin
    load_en   = 1'b0;
    load_byte = 8'h00;
    fold_en   = 1'b0;
    req       = 1'b0;
    case (state)
      HDR: begin
        load_en   = can_load;
        load_byte = idx[0] ? fun_r : id_r;
        fold_en   = can_load;
      end
      BODY: begin
        load_en = can_load;
        fold_en = can_load;
        if (mode_r) load_byte = count_r;
        else begin
          case (idx)
            2'd0:    load_byte = addr_r[15:8];
            2'd1:    load_byte = addr_r[7:0];
            2'd2:    load_byte = num_r[15:8];
            default: load_byte = num_r[7:0];
          endcase
        end
      end
      DATA: begin
        load_en   = pending;
        load_byte = payload_data;
        fold_en   = pending;
        req       = can_load & ~pending & (req_cnt != count_r);
      end
      CRC_LO: begin
        load_en   = can_load;
        load_byte = crc[7:0];
      end
      CRC_HI: begin
        load_en   = can_load & ~idx[0];
        load_byte = crc[15:8];
      end
      default: ;
    endcase
  end

  // Frame fields captured on an accepted start so callers may change inputs afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= 1'b0;
      id_r    <= 8'h00;
      fun_r   <= 8'h00;
      addr_r  <= 16'h0000;
      num_r   <= 16'h0000;
      count_r <= 8'h00;
    end else if (accept) begin
      mode_r  <= mode;
      id_r    <= slave_id;
      fun_r   <= fun;
      addr_r  <= start_addr;
      num_r   <= reg_num;
      count_r <= {reg_num[6:0], 1'b0};
    end
  end

  // Slot index within a state, payload request bookkeeping and the running CRC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= 2'd0;
      req_cnt <= 8'h00;
      pending <= 1'b0;
      crc     <= 16'hFFFF;
    end else begin
      if (state_next != state) idx <= 2'd0;
      else if (load_en)        idx <= idx + 2'd1;
      if (state != DATA)       req_cnt <= 8'h00;
      else if (req)            req_cnt <= req_cnt + 8'd1;
      pending <= req;
      if (accept)              crc <= 16'hFFFF;
      else if (fold_en)        crc <= crc_fold(crc, load_byte);
    end
  end

  // Output byte register: holds a byte stable until the UART accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (load_en) begin
      out_valid <= 1'b1;
      out_data  <= load_byte;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

  // Single-cycle completion and rejection pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= (state != IDLE) & (state_next == IDLE);
      err_r  <= (state == IDLE) & tx_start & bad_num;
    end
  end

  assign payload_req = req;
  assign byte_valid  = out_valid;
  assign byte_data   = out_data;
  assign busy        = (state != IDLE);
  assign tx_done     = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_mb_rtu_frame_tx.sv
// tb_mb_rtu_frame_tx: randomized self-checking bench for mb_rtu_frame_tx.
// Expected frames come from a queue-based frame model with a bitwise CRC model.
module tb_mb_rtu_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  slave_id = 8'h00;
  logic [7:0]  fun = 8'h00;
  logic [15:0] start_addr = 16'h0000;
  logic [15:0] reg_num = 16'h0000;
  logic        payload_req;
  logic [7:0]  payload_data = 8'h00;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready = 1'b0;
  logic        busy;
  logic        tx_done;
  logic        err;

  mb_rtu_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .mode(mode),
    .slave_id(slave_id), .fun(fun), .start_addr(start_addr), .reg_num(reg_num),
    .payload_req(payload_req), .payload_data(payload_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .busy(busy), .tx_done(tx_done), .err(err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  int cyc = 0, fires = 0, reqs = 0, dones = 0, errs = 0;
  int stall_bad = 0, req_b2b = 0, busy_bad = 0, valid_seen = 0, busy_seen = 0;
  int first_fire_cyc = 0, last_fire_cyc = 0, done_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay_mem[256];
  int pay_idx = 0;
  int ready_mode = 0;
  int stall_left = 0;
  logic prev_valid = 1'b0, prev_fire = 1'b0, prev_req = 1'b0, prev_rstn = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: records transfers, pulses and handshake rule violations.
  always @(negedge clk) begin
    cyc++;
    if (prev_rstn && rst_n && prev_valid && !prev_fire &&
        (!byte_valid || byte_data != prev_data)) stall_bad++;
    if (byte_valid && byte_ready) begin
      if (fires == 0) first_fire_cyc = cyc;
      last_fire_cyc = cyc;
      fires++;
      got_q.push_back(byte_data);
    end
    if (payload_req) begin
      reqs++;
      if (prev_req) req_b2b++;
    end
    if (tx_done) begin
      dones++;
      done_cyc = cyc;
      if (busy) busy_bad++;
    end
    if (err) errs++;
    if (byte_valid) valid_seen++;
    if (busy) busy_seen++;
    prev_valid = byte_valid;
    prev_fire  = byte_valid && byte_ready;
    prev_data  = byte_data;
    prev_req   = payload_req;
    prev_rstn  = rst_n;
  end

  // UART side: always ready, randomly ready, or stalling on data byte 0x12.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: byte_ready = 1'b1;
        1: byte_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (byte_valid && byte_data == 8'h12 && stall_left > 0) begin
            byte_ready = 1'b0;
            stall_left--;
          end else byte_ready = 1'b1;
        end
      endcase
    end
  end

  // Register storage: answers a payload request with data on the following cycle.
  initial begin
    logic r;
    forever begin
      @(negedge clk);
      r = payload_req;
      @(posedge clk);
      #1;
      if (r) begin
        payload_data = pay_mem[pay_idx];
        pay_idx++;
      end
    end
  end

  function automatic logic [15:0] modelCrc();
    logic [15:0] c = 16'hFFFF;
    foreach (exp_q[k]) begin
      for (int b = 0; b < 8; b++) begin
        logic lsb;
        lsb = c[0] ^ exp_q[k][b];
        c = {1'b0, c[15:1]};
        if (lsb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic buildFrame(input bit m, input logic [7:0] id, input logic [7:0] f,
                            input logic [15:0] a, input logic [15:0] n);
    logic [15:0] c;
    int cnt;
    exp_q.delete();
    exp_q.push_back(id);
    exp_q.push_back(f);
    if (!m) begin
      exp_q.push_back(a[15:8]);
      exp_q.push_back(a[7:0]);
      exp_q.push_back(n[15:8]);
      exp_q.push_back(n[7:0]);
    end else begin
      cnt = 2 * int'(n);
      exp_q.push_back(8'(cnt));
      for (int i = 0; i < cnt; i++) exp_q.push_back(pay_mem[i]);
    end
    c = modelCrc();
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic applyStimulus(input bit m, input logic [7:0] id, input logic [7:0] f,
                               input logic [15:0] a, input logic [15:0] n,
                               input int rmode, input bit mid_start);
    bit seen = 0;
    @(posedge clk);
    #1;
    got_q.delete();
    fires = 0; reqs = 0; dones = 0; errs = 0; pay_idx = 0;
    ready_mode = rmode;
    mode = m; slave_id = id; fun = f; start_addr = a; reg_num = n;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    mode = 1'($urandom); slave_id = 8'($urandom); fun = 8'($urandom);
    start_addr = 16'($urandom); reg_num = 16'($urandom);
    if (mid_start) begin
      repeat (3) @(posedge clk);
      #1;
      mode = 1'b1; reg_num = 16'd0; tx_start = 1'b1;
      @(posedge clk);
      #1;
      mode = 1'b0; reg_num = 16'd4; tx_start = 1'b1;
      @(posedge clk);
      #1;
      tx_start = 1'b0;
    end
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (tx_done) seen = 1;
    end
    checkOutput("done_timeout", 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput("frame_len", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    checkOutput("done_count", dones, 1);
    checkOutput("err_count", errs, 0);
    checkOutput("req_count", reqs, m ? 2 * int'(n) : 0);
    checkOutput("done_latency", done_cyc - last_fire_cyc, 1);
    if (!m && rmode == 0) checkOutput("back_to_back", last_fire_cyc - first_fire_cyc, 7);
  endtask

  task automatic checkReject(input logic [15:0] n);
    @(posedge clk);
    #1;
    errs = 0; valid_seen = 0; busy_seen = 0;
    mode = 1'b1; slave_id = 8'h01; fun = 8'h03; reg_num = n;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    @(negedge clk);
    checkOutput("err_pulse", 32'(err), 32'd1);
    repeat (6) @(negedge clk);
    checkOutput("err_once", errs, 1);
    checkOutput("err_no_valid", valid_seen, 0);
    checkOutput("err_no_busy", busy_seen, 0);
  endtask

  initial begin
    bit rm;
    logic [15:0] rn;
    int waited;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_byte_valid", 32'(byte_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tx_done", 32'(tx_done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_payload_req", 32'(payload_req), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    exp_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
    applyStimulus(1'b0, 8'h01, 8'h03, 16'h0000, 16'h000A, 0, 1'b0);
    exp_q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    applyStimulus(1'b0, 8'h01, 8'h06, 16'h0001, 16'h0003, 0, 1'b0);

    for (int i = 0; i < 6; i++) pay_mem[i] = 8'(8'h11 + i);
    buildFrame(1'b1, 8'h01, 8'h03, 16'h0000, 16'd3);
    applyStimulus(1'b1, 8'h01, 8'h03, 16'h0000, 16'd3, 0, 1'b0);
    stall_left = 5;
    applyStimulus(1'b1, 8'h01, 8'h03, 16'h0000, 16'd3, 2, 1'b0);
    checkOutput("stall_consumed", stall_left, 0);

    checkReject(16'd0);
    checkReject(16'd126);

    for (int i = 0; i < 256; i++) pay_mem[i] = 8'($urandom);
    buildFrame(1'b1, 8'h11, 8'h04, 16'h0000, 16'd125);
    applyStimulus(1'b1, 8'h11, 8'h04, 16'h0000, 16'd125, 1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      rm = 1'($urandom);
      rn = rm ? 16'($urandom_range(1, 6)) : 16'($urandom);
      for (int i = 0; i < 16; i++) pay_mem[i] = 8'($urandom);
      slave_id = 8'($urandom);
      buildFrame(rm, slave_id, 8'($urandom_range(1, 6)), 16'($urandom), rn);
      applyStimulus(rm, exp_q[0], exp_q[1], rm ? 16'h0000 : {exp_q[2], exp_q[3]}, rn, 1, t == 2);
    end

    @(posedge clk);
    #1;
    ready_mode = 0; fires = 0; dones = 0;
    mode = 1'b0; slave_id = 8'h01; fun = 8'h03; start_addr = 16'h0000; reg_num = 16'h000A;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    waited = 0;
    while (fires < 4 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reset_wait", 32'(fires >= 4), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(byte_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", dones, 0);
    exp_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
    applyStimulus(1'b0, 8'h01, 8'h03, 16'h0000, 16'h000A, 0, 1'b0);

    checkOutput("hold_violations", stall_bad, 0);
    checkOutput("req_outstanding", req_b2b, 0);
    checkOutput("busy_at_done", busy_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
